mac_dot4: RTL

MAC_DOT4 -- requirements
Module: mac_dot4

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mul_unit.sv | 13 +
 rtl/mac_dot4.sv | 98 +++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the four-element dot-product MAC: state encoding,
// element count and default operand/accumulator widths.
package mac_pkg;

  localparam int N_ELEM    = 4;
  localparam int DEF_WIDTH = 8;

  // Four full-scale products need two extra bits beyond one 2*W product.
  function automatic int acc_width(input int w);
    return 2 * w + 2;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_unit.sv
// Combinational unsigned WIDTH x WIDTH multiplier producing a full 2*WIDTH
// product; shared by the MAC datapath.
module mul_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mac_dot4.sv
// Four-element unsigned dot product computed serially through one shared
// multiplier: capture on start, four MAC cycles, one-cycle done pulse.
module mac_dot4
  import mac_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = acc_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] b3,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     a_in [N_ELEM];
  logic [WIDTH-1:0]     b_in [N_ELEM];
  logic [WIDTH-1:0]     a_q  [N_ELEM];
  logic [WIDTH-1:0]     b_q  [N_ELEM];

  assign a_in = '{a0, a1, a2, a3};
  assign b_in = '{b0, b1, b2, b3};

  // The single multiplier sees only the captured pair selected by idx.
  mul_unit #(.WIDTH(WIDTH)) u_mul (
    .a (a_q[idx]),
    .b (b_q[idx]),
    .p (prod)
  );

  assign acc_sum = acc + ACC_W'(prod);

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees pre-edge values, e.g. result takes acc_sum built from the old acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      // NOTE: the operand bank is a handful of flops, not a RAM, so clearing it
      // on reset is cheap and keeps post-reset state fully defined.
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            result <= acc_sum;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
